// File: rtl/sic_exec_alu_q.sv
// -----------------------------------------------------------------------------
// sic_exec_alu_q : SIC ALU execution sub-unit with an in-order issue queue.
//
// Purpose
//   Buffers up to DEPTH issued packets in a circular in-order queue. Only the
//   head entry is evaluated. It waits for register operands and ECR resolution,
//   arbitrates for the shared ALU through a request/grant lock, then commits
//   (GPR write and/or ECR slot resolution) or aborts on an ECR mispredict.
//
// Configuration
//   SIC_ALU_LOCK_HOLD_EN : when defined, the ALU lock is kept across
//   back-to-back commits. A release is issued only when the queue drains or
//   the next head aborts. When undefined, every commit is followed by a
//   release pulse and every packet re-arbitrates.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pkt_*               issue interface (valid/ready handshake plus payload)
//   rs_*/rt_*           head operand status and data from the register file
//   rd_commit/rd_wdata  GPR write strobe and data
//   head_issue_id/head_valid  head identification for the RF lookup
//   ecr_rd_*            ECR read port (head dependency lookup)
//   ecr_w*              ECR write port (branch resolution)
//   alu_req/alu_req_id/alu_grant/alu_release  shared ALU lock protocol
//   alu_op/alu_a/alu_b/alu_c/alu_zero         shared ALU datapath
// -----------------------------------------------------------------------------
module sic_exec_alu_q #(
    parameter  int DEPTH    = 2,
    parameter  int ID_WIDTH = 8,
    parameter  int NUM_ECR  = 2,
    localparam int ECR_W    = (NUM_ECR > 1) ? $clog2(NUM_ECR) : 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                pkt_valid,
    output logic                pkt_ready,
    input  logic [ID_WIDTH-1:0] pkt_issue_id,
    input  logic [3:0]          pkt_alu_op,
    input  logic                pkt_read_rs,
    input  logic                pkt_read_rt,
    input  logic                pkt_b_is_imm,
    input  logic [31:0]         pkt_imm,
    input  logic                pkt_write_gpr,
    input  logic                pkt_write_ecr,
    input  logic                pkt_pred_taken,
    input  logic                pkt_dep_ecr_v,
    input  logic [ECR_W-1:0]    pkt_dep_ecr_id,
    input  logic [ECR_W-1:0]    pkt_set_ecr_id,

    input  logic                rs_valid,
    input  logic                rt_valid,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,

    output logic                rd_commit,
    output logic [31:0]         rd_wdata,
    output logic [ID_WIDTH-1:0] head_issue_id,
    output logic                head_valid,

    output logic [ECR_W-1:0]    ecr_rd_addr,
    output logic                ecr_rd_en,
    input  logic [1:0]          ecr_rd_data,
    output logic                ecr_wen,
    output logic [ECR_W-1:0]    ecr_waddr,
    output logic [1:0]          ecr_wdata,

    output logic                alu_req,
    output logic [ID_WIDTH-1:0] alu_req_id,
    input  logic                alu_grant,
    output logic                alu_release,
    output logic [3:0]          alu_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_c,
    input  logic                alu_zero
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] ECR_CORRECT    = 2'b01;
    localparam logic [1:0] ECR_MISPREDICT = 2'b10;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [3:0]          op;
        logic                read_rs;
        logic                read_rt;
        logic                b_is_imm;
        logic [31:0]         imm;
        logic                write_gpr;
        logic                write_ecr;
        logic                pred_taken;
        logic                dep_ecr_v;
        logic [ECR_W-1:0]    dep_ecr_id;
        logic [ECR_W-1:0]    set_ecr_id;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             pkt_entry;
    entry_t             hd;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               lock_held;

    logic               push;
    logic               pop;
    logic               rf_ok;
    logic               ecr_ok;
    logic               abort;
    logic               commit;
    logic               next_head;
    logic               release_now;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign pkt_entry = '{
        id:         pkt_issue_id,
        op:         pkt_alu_op,
        read_rs:    pkt_read_rs,
        read_rt:    pkt_read_rt,
        b_is_imm:   pkt_b_is_imm,
        imm:        pkt_imm,
        write_gpr:  pkt_write_gpr,
        write_ecr:  pkt_write_ecr,
        pred_taken: pkt_pred_taken,
        dep_ecr_v:  pkt_dep_ecr_v,
        dep_ecr_id: pkt_dep_ecr_id,
        set_ecr_id: pkt_set_ecr_id
    };

    // Ready is derived from registered occupancy only: a full queue refuses
    // a push even when the head pops in the same cycle.
    assign pkt_ready  = (count < CNT_W'(DEPTH));
    assign push       = pkt_valid && pkt_ready;
    assign head_valid = (count != '0);
    assign hd         = mem[rd_ptr];

    // Head evaluation. Encoding 11 on the ECR read port counts as pending.
    always_comb begin
        rf_ok  = (!hd.read_rs || rs_valid) && (!hd.read_rt || rt_valid);
        ecr_ok = !hd.dep_ecr_v || (ecr_rd_data == ECR_CORRECT);
        abort  = head_valid && hd.dep_ecr_v && (ecr_rd_data == ECR_MISPREDICT);
        commit = head_valid && rf_ok && ecr_ok && alu_grant && !abort;
        pop    = commit || abort;
    end

    // Another entry is head next cycle if one is already queued behind the
    // current head, or one is being pushed behind a lone head.
    assign next_head = (count > CNT_W'(1)) || ((count == CNT_W'(1)) && push);

    always_comb begin
`ifdef SIC_ALU_LOCK_HOLD_EN
        release_now = (commit && !next_head) || (abort && lock_held);
`else
        release_now = commit || (abort && lock_held);
`endif
    end

    // Everything head-related reads as zero while the queue is empty.
    assign alu_req       = head_valid && !abort && !alu_release;
    assign alu_req_id    = head_valid ? hd.id : '0;
    assign head_issue_id = head_valid ? hd.id : '0;
    assign alu_op        = head_valid ? hd.op : '0;
    assign alu_a         = head_valid ? rs_data : '0;
    assign alu_b         = !head_valid ? '0 : (hd.b_is_imm ? hd.imm : rt_data);

    assign ecr_rd_en     = head_valid && hd.dep_ecr_v;
    assign ecr_rd_addr   = head_valid ? hd.dep_ecr_id : '0;

    assign rd_commit     = commit && hd.write_gpr;
    assign rd_wdata      = head_valid ? alu_c : '0;

    assign ecr_wen       = commit && hd.write_ecr;
    assign ecr_waddr     = head_valid ? hd.set_ecr_id : '0;
    assign ecr_wdata     = !head_valid ? 2'b00
                         : ((alu_zero == hd.pred_taken) ? ECR_CORRECT : ECR_MISPREDICT);

    // Control state: pointers, occupancy, lock tracking and the release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            lock_held   <= 1'b0;
            alu_release <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            alu_release <= release_now;
            if (release_now)
                lock_held <= 1'b0;
            else if (alu_req && alu_grant)
                lock_held <= 1'b1;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pkt_entry;
    end

endmodule

// File: doc/sic_exec_alu_q.md
Name: sic_exec_alu_q

Overview:
- Next-generation SIC ALU execution sub-unit.
- Buffers up to DEPTH issued packets in an in-order queue, so issue no longer stalls while the head waits on operands, ECR resolution or ALU arbitration.
- Executes the head entry against the shared ALU under a lock protocol.
- Commits ALU results to the register file and resolves branch ECR slots.
- The ECR file size is parametrised.

Parameters:
- DEPTH, 2, queue entries; legal range >=1.
- ID_WIDTH, 8, issue-id width.
- NUM_ECR, 2, ECR slots; localparam ECR_W = (NUM_ECR>1) ? $clog2(NUM_ECR) : 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pkt_valid  in  1  issue offers a packet.
- pkt_ready  out  1  queue can accept a packet.
- pkt_issue_id  in  ID_WIDTH  issue id.
- pkt_alu_op  in  4  ALU opcode.
- pkt_read_rs / pkt_read_rt  in  1 each  operand needed.
- pkt_b_is_imm  in  1  B operand is the immediate.
- pkt_imm  in  32  pre-extended immediate.
- pkt_write_gpr  in  1  write result to GPR.
- pkt_write_ecr  in  1  branch resolves an ECR slot.
- pkt_pred_taken  in  1  predicted direction.
- pkt_dep_ecr_v  in  1  packet depends on an ECR slot.
- pkt_dep_ecr_id  in  ECR_W  slot it depends on.
- pkt_set_ecr_id  in  ECR_W  slot it resolves.
- rs_valid / rt_valid  in  1 each  head operand ready.
- rs_data / rt_data  in  32 each  head operands.
- rd_commit  out  1  GPR write strobe.
- rd_wdata  out  32  GPR write data.
- head_issue_id  out  ID_WIDTH  head id (RF lookup).
- head_valid  out  1  queue non-empty.
- ecr_rd_addr  out  ECR_W  ECR read address.
- ecr_rd_en  out  1  ECR read enable.
- ecr_rd_data  in  2  00 pending, 01 correct, 10 mispredict, 11 reserved (treated as pending).
- ecr_wen  out  1  ECR write strobe.
- ecr_waddr  out  ECR_W  ECR write address.
- ecr_wdata  out  2  ECR write data.
- alu_req  out  1  ALU lock request.
- alu_req_id  out  ID_WIDTH  requester id.
- alu_grant  in  1  ALU lock granted.
- alu_release  out  1  ALU lock release pulse.
- alu_op  out  4  ALU opcode.
- alu_a / alu_b  out  32 each  ALU operands.
- alu_c  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset (async, any time, including mid-operation): queue emptied, count=0, alu_release=0, lock-held flag cleared. All outputs are 0 except pkt_ready=1. No release pulse is emitted for a lock held at reset.
- Queue: circular buffer with rd/wr pointers wrapping at DEPTH (DEPTH need not be a power of 2); count width is $clog2(DEPTH+1).
  - pkt_ready = (count<DEPTH), registered-state only; no full-bypass, so a push is refused when full even if the head pops the same cycle.
  - Push on pkt_valid&&pkt_ready. A push into an empty queue becomes head next cycle (1-cycle latency).
  - Simultaneous push and pop when not full: count unchanged.
- Head evaluation (combinational, only when head_valid):
  - rf_ok = (!read_rs||rs_valid)&&(!read_rt||rt_valid).
  - ecr_rd_en = dep_ecr_v; ecr_rd_addr = dep_ecr_id.
  - ecr_ok = !dep_ecr_v || rd_data==01.
  - abort = dep_ecr_v && rd_data==10.
  - alu_req = !abort && !alu_release, masked per optional feature; alu_req_id = head id.
  - alu_a = rs_data; alu_b = b_is_imm ? imm : rt_data.
  - commit = rf_ok && ecr_ok && alu_grant && !abort.
- Commit (pop):
  - rd_commit = commit && write_gpr; rd_wdata = alu_c.
  - ecr_wen = commit && write_ecr; ecr_waddr = set_ecr_id; ecr_wdata = (alu_zero==pred_taken) ? 01 : 10.
- Abort (pop): no RF or ECR write.
  - A lock held from a prior commit is released next cycle.
  - Abort and commit are mutually exclusive.
- Release: alu_release is a registered 1-cycle pulse, asserted the cycle after the lock is given up. alu_req is forced 0 during that cycle.
- Non-head entries never touch RF, ECR or ALU ports.

Optional Feature:
- Macro SIC_ALU_LOCK_HOLD_EN.
- Defined: the lock is kept across back-to-back commits.
  - On commit, if another entry will be head next cycle (count>1, or count==1 with a push that cycle), no release is issued. alu_req stays high and grant is assumed retained.
  - Release is issued only when the queue drains or the next head aborts.
- Undefined: a release pulse follows every commit, and every packet re-arbitrates.

Test Plan:
- Reset mid-flight with 2 entries queued and grant high -> next cycle count=0, pkt_ready=1, alu_release=0, no rd_commit.
- ADD, rs=5, rt=7, both valid, grant at cycle 3 -> rd_commit=1, rd_wdata=12 in cycle 3; alu_release=1 in cycle 4 (macro off).
- DEPTH=2: push 3 back-to-back with head waiting on rt_valid=0 -> third is refused (pkt_ready=0). A push while full and popping is still refused; it is accepted the next cycle.
- Head with dep_ecr_v=1, ecr_rd_data=00 for 4 cycles then 10 -> no alu_req during abort, entry popped, no RF/ECR write.
- BEQ, pred_taken=1, alu_zero=0, set_ecr_id=1 (NUM_ECR=4) -> ecr_wen=1, ecr_waddr=1, ecr_wdata=10.
- SIC_ALU_LOCK_HOLD_EN, 3 queued ALU packets, grant held -> 3 consecutive commits with alu_req high throughout, a single alu_release after the third commit.
